// File: rtl/fpumul_pipe.sv
// Pipelined multiplier for the extended-exponent FP format with valid/ready handshake and tag side-band.
// Macros: FPUMUL_PIPE_FLUSH_EN adds the flush port; swapedge moves state updates from negedge to posedge clk.
`ifdef swapedge
  `define FPUMUL_PIPE_EDGE posedge
`else
  `define FPUMUL_PIPE_EDGE negedge
`endif

module fpumul_pipe #(
  parameter int EXP_W  = 9,
  parameter int MANT_W = 23,
  parameter int STAGES = 3,
  parameter int TAG_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MANT_W:0]   A,
  input  logic [EXP_W+MANT_W:0]   B,
  input  logic                    copyA,
  input  logic [2:0]              rmode,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   res,
  output logic [TAG_W-1:0]        out_tag,
  output logic [4:0]              flags
`ifdef FPUMUL_PIPE_FLUSH_EN
  ,
  input  logic                    flush
`endif
);

  localparam int W    = 1 + EXP_W + MANT_W;
  localparam int MW   = MANT_W + 1;
  localparam int PW   = 2 * MW;
  localparam int XW   = EXP_W + 2;
  localparam int MID  = STAGES - 2;
  localparam int LAST = STAGES - 2;
  localparam int NCH  = (MID > 0) ? MID : 1;
  localparam int CH   = (MW + NCH - 1) / NCH;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;

  localparam logic [EXP_W-1:0]  EC_ZERO  = {EXP_W{1'b0}};
  localparam logic [EXP_W-1:0]  EC_INF   = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [EXP_W-1:0]  EC_NAN   = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]  EC_MAX   = {{(EXP_W-2){1'b1}}, 2'b01};
  localparam logic [MANT_W-1:0] NAN_MANT = {1'b1, {(MANT_W-2){1'b0}}, 1'b1};
  localparam logic [PW-1:0]     CH_MASK  = {PW{1'b1}} >> (PW - CH);

  typedef struct packed {
    logic              sign;
    logic [XW-1:0]     exp;
    logic [XW-1:0]     exp1;
    logic              special;
    logic [W-1:0]      sres;
    logic [4:0]        sflags;
    logic [2:0]        rm;
    logic [TAG_W-1:0]  tag;
    logic [MW-1:0]     ma;
    logic [MW-1:0]     mb;
    logic [PW-1:0]     acc;
  } stage_t;

  function automatic logic [W-1:0] pack_f(input logic s, input logic [EXP_W-1:0] e,
                                          input logic [MANT_W-1:0] m);
    return {e[EXP_W-1], s, e[EXP_W-2:0], m};
  endfunction

  stage_t              pipe_q [0:LAST];
  stage_t              pipe_d [0:LAST];
  logic                vld_q  [0:LAST];
  logic                out_valid_q;
  logic [W-1:0]        res_q, res_d;
  logic [4:0]          flags_q, flags_d;
  logic [TAG_W-1:0]    out_tag_q;
  logic                stall_s, flush_s, accept_s;
  stage_t              s1_d, fin_s;
  logic [EXP_W-1:0]    ea_s, eb_s;
  logic                za_s, zb_s, ia_s, ib_s, na_s, nb_s;
  logic [PW-1:0]       prod_n_s;
  logic signed [XW-1:0] e_n_s, e_f_s;
  logic [MANT_W-1:0]   mant_n_s;
  logic [MANT_W:0]     mant_r_s;
  logic                rbit_s, sticky_s, inc_s, inexact_s, sat_max_s;
  logic                unused_s;

`ifdef FPUMUL_PIPE_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  assign stall_s   = out_valid_q & ~out_ready;
  assign in_ready  = ~stall_s & ~flush_s;
  assign accept_s  = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign flags     = flags_q;
  assign out_tag   = out_tag_q;

  // Stage 1: decode operands, classify specials, form both exponent candidates
  always_comb begin
    ea_s = {A[W-1], A[W-3:MANT_W]};
    eb_s = {B[W-1], B[W-3:MANT_W]};
    za_s = (ea_s == EC_ZERO);
    zb_s = (eb_s == EC_ZERO);
    ia_s = (ea_s == EC_INF);
    ib_s = (eb_s == EC_INF);
    na_s = (ea_s == EC_NAN);
    nb_s = (eb_s == EC_NAN);
    s1_d      = '0;
    s1_d.sign = A[W-2] ^ B[W-2];
    s1_d.exp  = XW'(ea_s) + XW'(eb_s) - XW'(BIAS);
    s1_d.exp1 = XW'(ea_s) + XW'(eb_s) - XW'(BIAS - 1);
    s1_d.rm   = rmode;
    s1_d.tag  = in_tag;
    s1_d.ma   = {1'b1, A[MANT_W-1:0]};
    s1_d.mb   = {1'b1, B[MANT_W-1:0]};
    if (MID == 0) begin
      s1_d.acc = PW'(s1_d.ma) * PW'(s1_d.mb);
    end else begin
      s1_d.acc = {PW{1'b0}};
    end
    if (copyA) begin
      s1_d.special = 1'b1;
      s1_d.sres    = A;
      s1_d.sflags  = 5'b00001;
    end else if ((za_s & ib_s) | (ia_s & zb_s)) begin
      s1_d.special = 1'b1;
      s1_d.sres    = pack_f(1'b0, EC_NAN, NAN_MANT);
      s1_d.sflags  = 5'b00010;
    end else if (na_s | nb_s) begin
      s1_d.special = 1'b1;
      s1_d.sres    = pack_f(1'b0, EC_NAN, NAN_MANT);
      s1_d.sflags  = 5'b00000;
    end else if (ia_s | ib_s) begin
      s1_d.special = 1'b1;
      s1_d.sres    = pack_f(s1_d.sign, EC_INF, {MANT_W{1'b0}});
      s1_d.sflags  = 5'b00000;
    end else if (za_s | zb_s) begin
      s1_d.special = 1'b1;
      s1_d.sres    = pack_f(s1_d.sign, EC_ZERO, {MANT_W{1'b0}});
      s1_d.sflags  = 5'b00000;
    end else begin
      s1_d.special = 1'b0;
      s1_d.sres    = {W{1'b0}};
      s1_d.sflags  = 5'b00000;
    end
  end

  // Middle stages: each adds one CH-bit slice of mb times ma into the running product
  always_comb begin
    pipe_d[0] = s1_d;
    for (int i = 1; i <= LAST; i++) begin
      pipe_d[i]     = pipe_q[i-1];
      pipe_d[i].acc = pipe_q[i-1].acc +
                      ((PW'(pipe_q[i-1].ma) * ((PW'(pipe_q[i-1].mb) >> ((i-1) * CH)) & CH_MASK))
                       << ((i-1) * CH));
    end
  end

  // Final stage: normalise, round, then saturate on overflow or flush to zero on underflow
  always_comb begin
    fin_s     = pipe_q[LAST];
    prod_n_s  = fin_s.acc[PW-1] ? fin_s.acc : (fin_s.acc << 1);
    e_n_s     = fin_s.acc[PW-1] ? $signed(fin_s.exp1) : $signed(fin_s.exp);
    mant_n_s  = prod_n_s[PW-2 -: MANT_W];
    rbit_s    = prod_n_s[MANT_W];
    sticky_s  = |prod_n_s[MANT_W-1:0];
    inexact_s = rbit_s | sticky_s;
    case (fin_s.rm)
      3'd0:    inc_s = 1'b0;
      3'd1:    inc_s = rbit_s;
      3'd3:    inc_s = ~fin_s.sign & inexact_s;
      3'd4:    inc_s = fin_s.sign & inexact_s;
      default: inc_s = rbit_s & (sticky_s | mant_n_s[0]);
    endcase
    mant_r_s  = {1'b0, mant_n_s} + {{MANT_W{1'b0}}, inc_s};
    e_f_s     = e_n_s + $signed({{(XW-1){1'b0}}, mant_r_s[MANT_W]});
    sat_max_s = (fin_s.rm == 3'd0) | ((fin_s.rm == 3'd3) & fin_s.sign) |
                ((fin_s.rm == 3'd4) & ~fin_s.sign);
    if (fin_s.special) begin
      res_d   = fin_s.sres;
      flags_d = fin_s.sflags;
    end else if (e_f_s >= $signed({2'b00, EC_INF})) begin
      if (sat_max_s) begin
        res_d = pack_f(fin_s.sign, EC_MAX, {MANT_W{1'b1}});
      end else begin
        res_d = pack_f(fin_s.sign, EC_INF, {MANT_W{1'b0}});
      end
      flags_d = 5'b10100;
    end else if (e_f_s <= $signed({XW{1'b0}})) begin
      res_d   = pack_f(fin_s.sign, EC_ZERO, {MANT_W{1'b0}});
      flags_d = 5'b11000;
    end else begin
      res_d   = pack_f(fin_s.sign, e_f_s[EXP_W-1:0], mant_r_s[MANT_W-1:0]);
      flags_d = {inexact_s, 4'b0000};
    end
  end

  assign unused_s = ^{fin_s.ma, fin_s.mb, prod_n_s[PW-1]};

  // Pipeline and output registers; a stall freezes everything, flush drops all valid bits
  always_ff @(`FPUMUL_PIPE_EDGE clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= LAST; i++) begin
        pipe_q[i] <= '0;
        vld_q[i]  <= 1'b0;
      end
      out_valid_q <= 1'b0;
      res_q       <= {W{1'b0}};
      flags_q     <= 5'b00000;
      out_tag_q   <= {TAG_W{1'b0}};
    end else if (flush_s) begin
      for (int i = 0; i <= LAST; i++) begin
        vld_q[i] <= 1'b0;
      end
      out_valid_q <= 1'b0;
    end else if (!stall_s) begin
      vld_q[0]  <= accept_s;
      pipe_q[0] <= pipe_d[0];
      for (int i = 1; i <= LAST; i++) begin
        vld_q[i]  <= vld_q[i-1];
        pipe_q[i] <= pipe_d[i];
      end
      out_valid_q <= vld_q[LAST];
      if (vld_q[LAST]) begin
        res_q     <= res_d;
        flags_q   <= flags_d;
        out_tag_q <= fin_s.tag;
      end
    end
  end

endmodule

`undef FPUMUL_PIPE_EDGE

// File: tb/tb_fpumul_pipe.sv
// Scoreboard bench for fpumul_pipe (default parameters): expected results queued at accept, compared at output.
module tb_fpumul_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, copyA, out_valid, out_ready;
  logic [32:0] A, B, res;
  logic [2:0]  rmode;
  logic [5:0]  in_tag, out_tag;
  logic [4:0]  flags;
`ifdef FPUMUL_PIPE_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {logic [32:0] res; logic [4:0] flags; logic [5:0] tag;} exp_t;
  typedef struct packed {logic [32:0] a; logic [32:0] b; logic cp; logic [2:0] rm;
                         logic hand; logic [37:0] want;} op_t;
  exp_t       sb[$];
  op_t        ops[$];
  logic [5:0] tag_ctr = 6'd0;

  always #5 clk = ~clk;

  fpumul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .copyA(copyA), .rmode(rmode), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .out_tag(out_tag), .flags(flags)
`ifdef FPUMUL_PIPE_FLUSH_EN
    , .flush(flush)
`endif
  );

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Reference model: returns {flags, res}
  function automatic logic [37:0] ref_mul(input logic [32:0] a, input logic [32:0] b,
                                          input logic cp, input logic [2:0] rm);
    int          ea, eb, e;
    logic        s, nz, inc;
    logic [47:0] p, keep, rem, half;
    logic [8:0]  ev;
    logic [32:0] nan;
    nan = {1'b1, 1'b0, 8'hFF, 23'h400001};
    ea  = int'({a[32], a[30:23]});
    eb  = int'({b[32], b[30:23]});
    s   = a[31] ^ b[31];
    if (cp) return {5'b00001, a};
    if ((ea == 0 && eb == 510) || (ea == 510 && eb == 0)) return {5'b00010, nan};
    if (ea == 511 || eb == 511) return {5'b00000, nan};
    if (ea == 510 || eb == 510) return {5'b00000, 1'b1, s, 8'hFE, 23'h0};
    if (ea == 0 || eb == 0) return {5'b00000, 1'b0, s, 8'h00, 23'h0};
    p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    e = ea + eb - 255;
    if (p[47]) begin
      e++;
      keep = p >> 24; rem = p & 48'hFFFFFF; half = 48'h800000;
    end else begin
      keep = p >> 23; rem = p & 48'h7FFFFF; half = 48'h400000;
    end
    nz = (rem != 48'h0);
    case (rm)
      3'd0:    inc = 1'b0;
      3'd1:    inc = (rem >= half);
      3'd3:    inc = !s && nz;
      3'd4:    inc = s && nz;
      default: inc = (rem > half) || (rem == half && keep[0]);
    endcase
    keep = keep + {47'h0, inc};
    if (keep == 48'h1000000) begin
      keep = 48'h800000;
      e++;
    end
    if (e >= 510) begin
      if (rm == 3'd0 || (rm == 3'd3 && s) || (rm == 3'd4 && !s))
        return {5'b10100, 1'b1, s, 8'hFD, 23'h7FFFFF};
      return {5'b10100, 1'b1, s, 8'hFE, 23'h0};
    end
    if (e <= 0) return {5'b11000, 1'b0, s, 8'h00, 23'h0};
    ev = e[8:0];
    return {nz, 4'b0000, ev[8], s, ev[7:0], keep[22:0]};
  endfunction

  task automatic add_op(input logic [32:0] a, input logic [32:0] b, input logic cp, input logic [2:0] rm);
    ops.push_back({a, b, cp, rm, 1'b0, 38'h0});
  endtask

  task automatic add_hand(input logic [32:0] a, input logic [32:0] b, input logic cp, input logic [2:0] rm,
                          input logic [32:0] r, input logic [4:0] f);
    ops.push_back({a, b, cp, rm, 1'b1, f, r});
  endtask

  // Streams all queued ops back to back; optional fixed stall window or random backpressure
  task automatic run(input int stall_at, input int stall_len, input bit rand_bp, input bit chk_lat);
    int          cyc = 0, idx = 0, n_out = 0, first_v = -1, n_ops;
    logic [32:0] held = 33'h0;
    exp_t        e;
    logic [37:0] m;
    n_ops = ops.size();
    while ((idx < n_ops || sb.size() > 0) && cyc < 500) begin
      @(posedge clk);
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (idx < n_ops) begin
        in_valid = 1'b1; A = ops[idx].a; B = ops[idx].b; copyA = ops[idx].cp;
        rmode = ops[idx].rm; in_tag = tag_ctr;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && first_v < 0) first_v = cyc;
      if (stall_len > 0 && cyc == stall_at) begin
        check_eq("in_ready_stall", in_ready, 0);
        held = res;
      end
      if (stall_len > 0 && cyc == stall_at + stall_len - 1) check_eq("held_res", res, held);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq($sformatf("res#%0d", n_out), res, e.res);
          check_eq($sformatf("flags#%0d", n_out), flags, e.flags);
          check_eq($sformatf("tag#%0d", n_out), out_tag, e.tag);
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        m = ops[idx].hand ? ops[idx].want : ref_mul(ops[idx].a, ops[idx].b, ops[idx].cp, ops[idx].rm);
        e.res = m[32:0]; e.flags = m[37:33]; e.tag = tag_ctr;
        sb.push_back(e);
        idx++;
        tag_ctr++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (chk_lat) check_eq("latency", first_v, 3);
    check_eq("all_issued", idx, n_ops);
    check_eq("sb_drained", sb.size(), 0);
    check_eq("n_out", n_out, n_ops);
    ops.delete();
    sb.delete();
  endtask

  initial begin
    logic [32:0] a, b;
    logic [8:0]  ex;
    int          stale;
    rst = 1'b1; in_valid = 1'b0; A = 33'h0; B = 33'h0; copyA = 1'b0; rmode = 3'd0;
    in_tag = 6'd0; out_ready = 1'b1;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_res", res, 0);
    check_eq("rst_flags", flags, 0);
    check_eq("rst_out_tag", out_tag, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    add_hand(33'h0_7F80_0000, 33'h1_0000_0000, 1'b0, 3'd2, 33'h1_0000_0000, 5'b00000);
    run(-1, 0, 1'b0, 1'b1);

    add_hand(33'h0_7FC0_0000, 33'h0_7FC0_0000, 1'b0, 3'd2, 33'h1_0010_0000, 5'b00000);
    add_hand(33'h0_7FFF_FFFF, 33'h0_7FFF_FFFF, 1'b0, 3'd0, 33'h1_007F_FFFE, 5'b10000);
    add_hand(33'h0_7FFF_FFFF, 33'h0_7FFF_FFFF, 1'b0, 3'd2, 33'h1_007F_FFFE, 5'b10000);
    add_hand(33'h0_7FFF_FFFF, 33'h0_7FFF_FFFF, 1'b0, 3'd3, 33'h1_007F_FFFF, 5'b10000);
    add_hand(33'h0_7F80_0003, 33'h0_7FC0_0000, 1'b0, 3'd2, 33'h0_7FC0_0004, 5'b10000);
    add_hand(33'h0_7F80_0003, 33'h0_7FC0_0000, 1'b0, 3'd1, 33'h0_7FC0_0005, 5'b10000);
    add_hand(33'h1_7E80_0000, 33'h1_7E80_0000, 1'b0, 3'd2, 33'h1_7F00_0000, 5'b10100);
    add_hand(33'h1_7E80_0000, 33'h1_7E80_0000, 1'b0, 3'd0, 33'h1_7EFF_FFFF, 5'b10100);
    add_hand(33'h0_0080_0000, 33'h0_0080_0000, 1'b0, 3'd2, 33'h0_0000_0000, 5'b11000);
    add_hand(33'h0_0000_0000, 33'h1_7F00_0000, 1'b0, 3'd2, 33'h1_7FC0_0001, 5'b00010);
    add_hand(33'h0_1234_5678, 33'h1_7F00_0000, 1'b1, 3'd2, 33'h0_1234_5678, 5'b00001);
    add_op(33'h0_7FFF_FFFF, 33'h0_7FFF_FFFF, 1'b0, 3'd1);
    add_op(33'h0_7FFF_FFFF, 33'h0_FFFF_FFFF, 1'b0, 3'd4);
    add_op(33'h1_FE80_0000, 33'h1_7E80_0000, 1'b0, 3'd3);
    add_op(33'h1_7E80_0000, 33'h1_7E80_0000, 1'b0, 3'd4);
    add_op(33'h1_7E80_0000, 33'h1_FE80_0000, 1'b0, 3'd6);
    add_op(33'h1_7F80_0001, 33'h0_7F80_0000, 1'b0, 3'd2);
    add_op(33'h1_7F80_0001, 33'h0_0000_0000, 1'b0, 3'd2);
    add_op(33'h1_7F00_0000, 33'h0_FF80_0000, 1'b0, 3'd2);
    add_op(33'h1_7F00_0000, 33'h0_0000_0000, 1'b0, 3'd2);
    add_op(33'h0_8000_0000, 33'h1_0000_0000, 1'b0, 3'd2);
    run(-1, 0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      a = {1'b0, 1'(i), 8'hFF, 23'(i * 32'h12345)};
      b = {1'b0, 1'b0, 8'hF0 + 8'(i), 23'h7FFFFF - 23'(i * 32'h3131)};
      add_op(a, b, 1'b0, 3'(i));
    end
    run(4, 4, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      a = {$urandom_range(0, 1), $urandom()};
      b = {$urandom_range(0, 1), $urandom()};
      if (i % 2 == 0) begin
        ex = 9'($urandom_range(200, 310)); a = {ex[8], a[31], ex[7:0], a[22:0]};
        ex = 9'($urandom_range(200, 310)); b = {ex[8], b[31], ex[7:0], b[22:0]};
      end
      add_op(a, b, ($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)));
    end
    run(-1, 0, 1'b1, 1'b0);

    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      in_valid = 1'b1; A = 33'h0_7FC0_0000; B = 33'h0_7F80_0000; rmode = 3'd2; copyA = 1'b0;
      in_tag = 6'(k);
      #1;
      if (k == 3) check_eq("pre_rst_out_valid", out_valid, 1);
    end
    rst = 1'b1;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_res", res, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    stale = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    check_eq("stale_after_rst", stale, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
